// File: rtl/inst_fetch_responder_pkg.sv
// Shared constants for the instruction-fetch responder: FSM encodings,
// reset vector and the word returned on a faulting fetch.
package inst_fetch_responder_pkg;

  localparam logic [1:0] IFR_IDLE = 2'd0;
  localparam logic [1:0] IFR_WAIT = 2'd1;
  localparam logic [1:0] IFR_RESP = 2'd2;

  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] IFR_ERR_INST = 32'h0010_0073;

endpackage

// File: rtl/inst_mem_array.sv
// Word-addressed instruction store: synchronous write, combinational read.
module inst_mem_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
  input  logic [31:0]                    wr_data,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
  output logic [31:0]                    rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/inst_fetch_responder.sv
// Fixed-latency instruction fetch responder with valid/ready handshakes,
// address checking and a loader write port into the backing array.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = RESET_VECTOR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] ERR_INST    = IFR_ERR_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] fetch_cnt
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  // Offset is taken modulo 2^32, so addresses below the base wrap high and fail the range test.
  function automatic logic addr_bad(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return (addr[1:0] != 2'b00) || (off >= SPAN_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'((addr - ADDR_BASE) >> 2);
  endfunction

  logic [1:0]  state;
  logic [3:0]  cnt_p0;
  logic [31:0] addr_p0;
  logic [31:0] rd_data;

  assign req_ready = (state == IFR_IDLE);

  inst_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk    (clk),
    .wr_en  (load_en && !addr_bad(load_addr)),
    .wr_idx (word_idx(load_addr)),
    .wr_data(load_data),
    .rd_idx (word_idx(addr_p0)),
    .rd_data(rd_data)
  );

  // Stage p0: request address captured at acceptance
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) addr_p0 <= req_addr;
  end

  // Response stage: control FSM, latency count and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IFR_IDLE;
      cnt_p0     <= '0;
      resp_valid <= 1'b0;
      resp_inst  <= '0;
      resp_err   <= 1'b0;
      fetch_cnt  <= '0;
    end else begin
      case (state)
        IFR_IDLE: begin
          if (req_valid) begin
            cnt_p0 <= CNT_INIT;
            state  <= (LATENCY == 1) ? IFR_RESP : IFR_WAIT;
          end
        end
        IFR_WAIT: begin
          cnt_p0 <= cnt_p0 - 4'd1;
          if (cnt_p0 == 4'd1) state <= IFR_RESP;
        end
        IFR_RESP: begin
          // First RESP edge samples the array before any same-edge load lands.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_err   <= addr_bad(addr_p0);
            resp_inst  <= addr_bad(addr_p0) ? ERR_INST : rd_data;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            fetch_cnt  <= fetch_cnt + 32'd1;
            state      <= IFR_IDLE;
          end
        end
        default: state <= IFR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=1 instance for back-to-back throughput.
module tb_inst_fetch_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, load_en;
  logic [31:0] req_addr, resp_inst, load_addr, load_data, fetch_cnt;

  logic        req_valid1, req_ready1, resp_valid1, resp_ready1, resp_err1, load_en1;
  logic [31:0] req_addr1, resp_inst1, load_addr1, load_data1, fetch_cnt1;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  inst_fetch_responder #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .fetch_cnt(fetch_cnt)
  );

  inst_fetch_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_inst(resp_inst1), .resp_err(resp_err1),
    .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1),
    .fetch_cnt(fetch_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic load1(input logic [31:0] a, input logic [31:0] d);
    load_en1 = 1'b1; load_addr1 = a; load_data1 = d;
    tick();
    load_en1 = 1'b0;
  endtask

  // With clash set, a load of cd to the same word is presented on the capture edge.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] ei,
                       input logic ee, input logic clash, input logic [31:0] cd);
    chk({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0; req_addr = 32'h0;
    chk({tag, ".valid_k"}, 32'(resp_valid), 32'd0);
    tick();
    chk({tag, ".valid_k1"}, 32'(resp_valid), 32'd0);
    chk({tag, ".req_ready_busy"}, 32'(req_ready), 32'd0);
    if (clash) begin
      load_en = 1'b1; load_addr = a; load_data = cd;
    end
    tick();
    load_en = 1'b0;
    chk({tag, ".valid_k2"}, 32'(resp_valid), 32'd1);
    chk({tag, ".inst"}, resp_inst, ei);
    chk({tag, ".err"}, 32'(resp_err), 32'(ee));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    exp_cnt++;
    chk({tag, ".valid_done"}, 32'(resp_valid), 32'd0);
    chk({tag, ".req_ready_done"}, 32'(req_ready), 32'd1);
    chk({tag, ".fetch_cnt"}, fetch_cnt, 32'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    req_valid1 = 1'b0; req_addr1 = '0; resp_ready1 = 1'b0;
    load_en1 = 1'b0; load_addr1 = '0; load_data1 = '0;
    tick();
    tick();
    chk("rst.valid", 32'(resp_valid), 32'd0);
    chk("rst.inst", resp_inst, 32'h0);
    chk("rst.err", 32'(resp_err), 32'd0);
    chk("rst.fetch_cnt", fetch_cnt, 32'h0);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    rst = 1'b1;
    tick();

    load(32'h8000_0000, 32'h0000_0513);
    load(32'h8000_0004, 32'h00A0_0593);
    load(32'h8000_0FFC, 32'h1234_5678);

    fetch("basic", 32'h8000_0000, 32'h0000_0513, 1'b0, 1'b0, 32'h0);

    // Backpressure: response held for 5 cycles
    req_valid = 1'b1; req_addr = 32'h8000_0000;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("bp.valid", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.hold_valid", 32'(resp_valid), 32'd1);
      chk("bp.hold_inst", resp_inst, 32'h0000_0513);
      chk("bp.hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    exp_cnt++;
    chk("bp.release_valid", 32'(resp_valid), 32'd0);
    chk("bp.release_req_ready", 32'(req_ready), 32'd1);
    chk("bp.fetch_cnt", fetch_cnt, 32'(exp_cnt));

    fetch("misaligned", 32'h8000_0002, 32'h0010_0073, 1'b1, 1'b0, 32'h0);
    fetch("out_of_range", 32'h8000_1000, 32'h0010_0073, 1'b1, 1'b0, 32'h0);

    load(32'h7FFF_FFFC, 32'hBAD0_BAD0);
    fetch("oor_load_dropped", 32'h8000_0FFC, 32'h1234_5678, 1'b0, 1'b0, 32'h0);

    fetch("clash_old", 32'h8000_0004, 32'h00A0_0593, 1'b0, 1'b1, 32'hDEAD_BEEF);
    fetch("clash_new", 32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);

    // Reset during WAIT aborts the transaction
    req_valid = 1'b1; req_addr = 32'h8000_0000;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_wait.valid", 32'(resp_valid), 32'd0);
    chk("rst_wait.fetch_cnt", fetch_cnt, 32'h0);
    tick();
    rst = 1'b1;
    exp_cnt = 0;
    tick();
    tick();
    tick();
    chk("rst_wait.valid_after", 32'(resp_valid), 32'd0);
    chk("rst_wait.req_ready", 32'(req_ready), 32'd1);
    chk("rst_wait.fetch_cnt_after", fetch_cnt, 32'(exp_cnt));

    // LATENCY=1 back-to-back fetches, 3-cycle period
    load1(32'h8000_0000, 32'h1111_1111);
    load1(32'h8000_0004, 32'h2222_2222);
    resp_ready1 = 1'b1;
    req_valid1 = 1'b1; req_addr1 = 32'h8000_0000;
    tick();
    req_addr1 = 32'h8000_0004;
    chk("l1.a_valid_k", 32'(resp_valid1), 32'd0);
    chk("l1.a_req_ready_k", 32'(req_ready1), 32'd0);
    tick();
    chk("l1.a_valid_k1", 32'(resp_valid1), 32'd1);
    chk("l1.a_inst", resp_inst1, 32'h1111_1111);
    chk("l1.a_err", 32'(resp_err1), 32'd0);
    tick();
    chk("l1.a_done_valid", 32'(resp_valid1), 32'd0);
    chk("l1.a_done_req_ready", 32'(req_ready1), 32'd1);
    tick();
    req_valid1 = 1'b0;
    chk("l1.b_valid_k", 32'(resp_valid1), 32'd0);
    chk("l1.b_req_ready_k", 32'(req_ready1), 32'd0);
    tick();
    chk("l1.b_valid_k1", 32'(resp_valid1), 32'd1);
    chk("l1.b_inst", resp_inst1, 32'h2222_2222);
    tick();
    resp_ready1 = 1'b0;
    chk("l1.b_done_valid", 32'(resp_valid1), 32'd0);
    chk("l1.fetch_cnt", fetch_cnt1, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
